// File: rtl/pwm_gen.sv
// pwm_gen -- fixed-on-time PWM generator, consumer side of the
// pwm_en / pwm_rdy / off_div handshake with pwm_ctl.
//
// Each period:
//   ON   : pwm_out high for ON_TIME cycles. A one-cycle pwm_en request
//          is issued in the first ON cycle.
//   WAIT : entered only if the request has not completed by the last ON cycle.
//   OFF  : pwm_out low for div_act cycles, where div_act is the latched off_div.
// enable is honoured only in IDLE and at the OFF->ON decision, so a
// period is never truncated.
//
// Optional feature: define PWM_GEN_DEADTIME_EN to drive pwm_out_n high
// inside OFF, with DEAD_TIME guard cycles at both ends. Without it,
// pwm_out_n is tied low.
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   enable       run request
//   off_div      off count from controller (valid once request completes)
//   pwm_rdy      controller idle/ready
//   pwm_en       one-cycle request pulse to controller
//   pwm_out      main gate drive
//   pwm_out_n    complementary gate drive
//   period_done  one-cycle pulse on last OFF cycle
//   stall        high while waiting on controller
//   div_act      off count in use for current period

module pwm_gen #(
  parameter int ON_TIME     = 40,
  parameter int CNT_WIDTH   = 18,
  parameter int MIN_OFF_DIV = 1,
  parameter int DEAD_TIME   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [CNT_WIDTH-1:0] off_div,
  input  logic                 pwm_rdy,
  output logic                 pwm_en,
  output logic                 pwm_out,
  output logic                 pwm_out_n,
  output logic                 period_done,
  output logic                 stall,
  output logic [CNT_WIDTH-1:0] div_act
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ON,
    ST_WAIT,
    ST_OFF
  } state_t;

  localparam logic [CNT_WIDTH-1:0] ON_LAST = CNT_WIDTH'(ON_TIME - 1);
  localparam logic [CNT_WIDTH-1:0] MIN_DIV = CNT_WIDTH'(MIN_OFF_DIV);
  localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);

  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] on_cnt, on_cnt_nxt;
  logic [CNT_WIDTH-1:0] off_cnt, off_cnt_nxt;
  logic [CNT_WIDTH-1:0] div_act_nxt;
  logic                 busy_seen, busy_seen_nxt;
  logic                 done, done_nxt;

  logic                 req_cycle;
  logic                 complete;
  logic [CNT_WIDTH-1:0] div_clamped;

  // The request cycle is the first ON cycle.
  assign req_cycle = (state == ST_ON) && (on_cnt == '0);

  // done/busy_seen still hold the previous period's values during the
  // request cycle. That matters when ON_TIME=1, because the request cycle is
  // also the last ON cycle. Masking with req_cycle makes the cycle behave as
  // already cleared. The second term is "done is being set this cycle".
  assign complete = !req_cycle && (done || (busy_seen && pwm_rdy));

  // A set MSB means the controller wrapped negative, so treat it as zero.
  always_comb begin
    div_clamped = off_div;
    if (off_div[CNT_WIDTH-1] || (off_div < MIN_DIV)) begin
      div_clamped = MIN_DIV;
    end
  end

  // Request tracking. pwm_rdy must be seen low before a high level counts as
  // completion, so a stale-high pwm_rdy right after the pulse is ignored.
  always_comb begin
    busy_seen_nxt = busy_seen;
    done_nxt      = done;
    if (req_cycle) begin
      busy_seen_nxt = 1'b0;
      done_nxt      = 1'b0;
    end else if (!pwm_rdy) begin
      busy_seen_nxt = 1'b1;
    end else if (busy_seen) begin
      done_nxt = 1'b1;
    end
  end

  always_comb begin
    state_nxt   = state;
    on_cnt_nxt  = on_cnt;
    off_cnt_nxt = off_cnt;
    div_act_nxt = div_act;
    unique case (state)
      ST_IDLE: begin
        if (enable) begin
          state_nxt  = ST_ON;
          on_cnt_nxt = '0;
        end
      end
      ST_ON: begin
        if (on_cnt == ON_LAST) begin
          on_cnt_nxt = '0;
          if (complete) begin
            div_act_nxt = div_clamped;
            off_cnt_nxt = ONE;
            state_nxt   = ST_OFF;
          end else begin
            state_nxt = ST_WAIT;
          end
        end else begin
          on_cnt_nxt = on_cnt + ONE;
        end
      end
      ST_WAIT: begin
        if (complete) begin
          div_act_nxt = div_clamped;
          off_cnt_nxt = ONE;
          state_nxt   = ST_OFF;
        end
      end
      ST_OFF: begin
        if (off_cnt == div_act) begin
          off_cnt_nxt = '0;
          on_cnt_nxt  = '0;
          state_nxt   = enable ? ST_ON : ST_IDLE;
        end else begin
          off_cnt_nxt = off_cnt + ONE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      on_cnt    <= '0;
      off_cnt   <= '0;
      div_act   <= MIN_DIV;
      busy_seen <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      on_cnt    <= on_cnt_nxt;
      off_cnt   <= off_cnt_nxt;
      div_act   <= div_act_nxt;
      busy_seen <= busy_seen_nxt;
      done      <= done_nxt;
    end
  end

  // All outputs decode directly from registered state. Reset therefore
  // clears them on the next edge.
  assign pwm_out     = (state == ST_ON);
  assign pwm_en      = req_cycle;
  assign stall       = (state == ST_WAIT);
  assign period_done = (state == ST_OFF) && (off_cnt == div_act);

`ifdef PWM_GEN_DEADTIME_EN
  localparam logic [CNT_WIDTH-1:0] DT  = CNT_WIDTH'(DEAD_TIME);
  localparam logic [CNT_WIDTH:0]   DT2 = (CNT_WIDTH + 1)'(2 * DEAD_TIME);

  // The div_act > 2*DT guard also keeps div_act - DT from underflowing.
  assign pwm_out_n = (state == ST_OFF) &&
                     ({1'b0, div_act} > DT2) &&
                     (off_cnt > DT) &&
                     (off_cnt <= (div_act - DT));
`else
  logic [31:0] unused_dead_time;
  assign unused_dead_time = DEAD_TIME;
  assign pwm_out_n        = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_gen.sv
// tb_pwm_gen -- scoreboard bench for pwm_gen (ON_TIME=40, DEAD_TIME=3).
// Stimulus pushes the expected shape of each period into a queue. A monitor
// measures every period and compares it on period_done. A controller stub
// answers pwm_en. It drops pwm_rdy on the cycle after the pulse, and raises
// it again in cycle resp_cyc counted from the pulse cycle.

module tb_pwm_gen;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [17:0] off_div;
  logic        pwm_rdy;
  logic        pwm_en;
  logic        pwm_out;
  logic        pwm_out_n;
  logic        period_done;
  logic        stall;
  logic [17:0] div_act;

  pwm_gen #(
    .ON_TIME    (40),
    .CNT_WIDTH  (18),
    .MIN_OFF_DIV(1),
    .DEAD_TIME  (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .off_div    (off_div),
    .pwm_rdy    (pwm_rdy),
    .pwm_en     (pwm_en),
    .pwm_out    (pwm_out),
    .pwm_out_n  (pwm_out_n),
    .period_done(period_done),
    .stall      (stall),
    .div_act    (div_act)
  );

  // Expected complementary-drive high counts for each off_div used.
`ifdef PWM_GEN_DEADTIME_EN
  localparam int N100 = 94;  // off_cnt 4..97
  localparam int N7   = 1;   // off_cnt 4 only
`else
  localparam int N100 = 0;
  localparam int N7   = 0;
`endif

  typedef struct {
    int on_len;
    int wait_len;
    int off_len;
    int div;
    int outn;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   resp_cyc = 4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else n_pass++;
  endtask

  task automatic push(input int on_len, input int wait_len, input int off_len,
                      input int div, input int outn);
    exp_t e;
    e.on_len   = on_len;
    e.wait_len = wait_len;
    e.off_len  = off_len;
    e.div      = div;
    e.outn     = outn;
    sb.push_back(e);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 3000) begin
      step();
      n++;
    end
    check({"drain_", name}, sb.size(), 0);
  endtask

  // Controller stub.
  initial begin
    int since = -1;
    pwm_rdy = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        since   = -1;
        pwm_rdy = 1'b1;
      end else if (pwm_en) begin
        since   = 0;
        pwm_rdy = 1'b1;
      end else if (since >= 0) begin
        since++;
        pwm_rdy = (since >= resp_cyc);
      end
    end
  end

  // Monitor: measures each period from pwm_en to period_done.
  initial begin
    bit in_period = 0;
    int on_c = 0, wait_c = 0, off_c = 0, en_c = 0, outn_c = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_period = 0;
      end else begin
        if (pwm_en) begin
          if (in_period) begin
            en_c++;
          end else begin
            in_period = 1;
            on_c      = 0;
            wait_c    = 0;
            off_c     = 0;
            outn_c    = 0;
            en_c      = 1;
          end
        end
        if (in_period) begin
          if (pwm_out) on_c++;
          else if (stall) wait_c++;
          else off_c++;
          if (pwm_out_n) outn_c++;
        end
        if (period_done) begin
          check("period_expected", sb.size() != 0, 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("on_len", on_c, e.on_len);
            check("wait_len", wait_c, e.wait_len);
            check("off_len", off_c, e.off_len);
            check("div_act", div_act, e.div);
            check("outn_len", outn_c, e.outn);
            check("en_pulses", en_c, 1);
          end
          in_period = 0;
        end
      end
    end
  end

  initial begin
    int hi_c;
    int en_c;
    rst     = 1'b1;
    enable  = 1'b0;
    off_div = 18'd100;
    repeat (3) step();
    check("rst_pwm_out", pwm_out, 0);
    check("rst_pwm_out_n", pwm_out_n, 0);
    check("rst_pwm_en", pwm_en, 0);
    check("rst_period_done", period_done, 0);
    check("rst_stall", stall, 0);
    check("rst_div_act", div_act, 1);
    rst = 1'b0;
    repeat (5) step();
    check("idle_pwm_out", pwm_out, 0);
    check("idle_pwm_en", pwm_en, 0);

    // Nominal: 40 high, 100 low.
    push(40, 0, 100, 100, N100);
    push(40, 0, 100, 100, N100);
    enable = 1'b1;
    step();
    check("en_rise_pwm_out", pwm_out, 1);
    check("en_rise_pwm_en", pwm_en, 1);
    drain("nominal");

    // Slow controller: rdy returns in cycle 59, giving WAIT cycles 40..59.
    resp_cyc = 59;
    push(40, 20, 100, 100, N100);
    drain("wait");
    resp_cyc = 4;

    // Clamp and dead-time boundaries.
    off_div = 18'd0;
    push(40, 0, 1, 1, 0);
    drain("div_zero");
    off_div = 18'h20000;
    push(40, 0, 1, 1, 0);
    drain("div_msb");
    off_div = 18'd6;
    push(40, 0, 6, 6, 0);
    drain("div_6");
    off_div = 18'd7;
    push(40, 0, 7, 7, N7);
    drain("div_7");

    // Drop enable in ON cycle 10. The period still completes in full.
    off_div = 18'd100;
    push(40, 0, 100, 100, N100);
    repeat (11) step();
    enable = 1'b0;
    drain("enable_drop");
    hi_c = 0;
    en_c = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (pwm_out) hi_c++;
      if (pwm_en) en_c++;
    end
    check("idle_after_drop_out", hi_c, 0);
    check("idle_after_drop_en", en_c, 0);
    check("div_act_held", div_act, 100);

    // Reset in OFF cycle 50 (ON cycle 0 is at step 1, OFF cycle j at step 40+j).
    enable = 1'b1;
    repeat (90) step();
    check("pre_rst_in_off", pwm_out | stall, 0);
    rst = 1'b1;
    step();
    check("mid_rst_pwm_out", pwm_out, 0);
    check("mid_rst_pwm_out_n", pwm_out_n, 0);
    check("mid_rst_pwm_en", pwm_en, 0);
    check("mid_rst_period_done", period_done, 0);
    check("mid_rst_stall", stall, 0);
    check("mid_rst_div_act", div_act, 1);
    push(40, 0, 100, 100, N100);
    rst = 1'b0;
    step();
    check("restart_pwm_en", pwm_en, 1);
    check("restart_pwm_out", pwm_out, 1);
    enable = 1'b0;
    drain("restart");
    repeat (10) step();
    check("final_idle", pwm_out, 0);
    check("final_sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
